// File: rtl/stop_it_ctrl.sv
// Stop-it game sequencer: drives the LED shifter's load/shift/blank strobes, judges stops, keeps score.
// load_o/shift_o decode from state and counters; the remaining outputs are registered.
module stop_it_ctrl #(
  parameter int SHIFT_PERIOD = 1000000,
  parameter int BLINK_PERIOD = 4000000,
  parameter int BLINK_COUNT  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [3:0]  target_i,
  input  logic [15:0] leds_i,
  output logic        shift_o,
  output logic        load_o,
  output logic        off_o,
  output logic        running_o,
  output logic        win_o,
  output logic        lose_o,
  output logic [3:0]  score_o
);

  localparam int TW    = $clog2(SHIFT_PERIOD);
  localparam int HW    = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int NHALF = 2 * BLINK_COUNT;
  localparam int BW    = $clog2(NHALF);

  localparam logic [TW-1:0] TICK_LAST  = TW'(SHIFT_PERIOD - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(NHALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_JUDGE,
    S_WIN,
    S_LOSE
  } state_t;

  state_t          state_q, state_d;
  logic            start_q, stop_q;
  logic [TW-1:0]   tick_q, tick_d;
  logic [HW-1:0]   half_q, half_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic [3:0]      score_q, score_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic            off_q, off_d;

  logic            start_e, stop_e;
  logic            tick_wrap, leds_full, blink_done, hit;
  logic [3:0]      target_nxt;

  assign start_e    = start_i & ~start_q;
  assign stop_e     = stop_i & ~stop_q;
  assign tick_wrap  = (tick_q == TICK_LAST);
  assign leds_full  = (leds_i == 16'hFFFF);
  assign blink_done = (half_q == HALF_LAST) && (blink_q == BLINK_LAST);

  // Hit means the fill front sits exactly on the target: target lit, the LED above it dark.
  assign target_nxt = target_i + 4'd1;
  assign hit        = leds_i[target_i] & ((target_i == 4'd15) | ~leds_i[target_nxt]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      tick_q  <= '0;
      half_q  <= '0;
      blink_q <= '0;
      score_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      off_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      stop_q  <= stop_i;
      tick_q  <= tick_d;
      half_q  <= half_d;
      blink_q <= blink_d;
      score_q <= score_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_LOSE: if (start_e) state_d = S_LOAD;
      S_LOAD:         state_d = S_RUN;
      S_RUN: begin
        if (stop_e)         state_d = S_JUDGE;
        else if (leds_full) state_d = S_LOSE;
      end
      S_JUDGE:        state_d = hit ? S_WIN : S_LOSE;
      S_WIN:          if (blink_done) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_d  = '0;
    half_d  = '0;
    blink_d = '0;
    if (state_q == S_RUN && !tick_wrap) begin
      tick_d = tick_q + TW'(1);
    end
    // Blink counters start from zero on WIN entry and only advance while staying in WIN.
    if (state_q == S_WIN && state_d == S_WIN) begin
      if (half_q == HALF_LAST) begin
        blink_d = blink_q + BW'(1);
      end else begin
        half_d  = half_q + HW'(1);
        blink_d = blink_q;
      end
    end
    off_d   = (state_d == S_WIN) && !blink_d[0];
    win_d   = (state_q == S_JUDGE) && hit;
    lose_d  = (state_d == S_LOSE) && (state_q != S_LOSE);
    score_d = (win_d && score_q != 4'd15) ? score_q + 4'd1 : score_q;
  end

  always_comb begin
    load_o    = (state_q == S_LOAD);
    shift_o   = (state_q == S_RUN) && tick_wrap && !stop_e;
    running_o = (state_q == S_RUN);
    off_o     = off_q;
    win_o     = win_q;
    lose_o    = lose_q;
    score_o   = score_q;
  end

endmodule

// File: tb/tb_stop_it_ctrl.sv
// Bench for stop_it_ctrl: a shifter model feeds leds_i back, expected strobe cycles are queued up front.
module tb_stop_it_ctrl;

  localparam int SP = 4;
  localparam int BP = 3;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stop_i;
  logic [3:0]  target_i;
  logic [15:0] leds = 16'h0000;
  logic        shift_o, load_o, off_o, running_o, win_o, lose_o;
  logic [3:0]  score_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int score_m = 0;

  typedef struct {
    int cyc;
    int v;
  } off_t;

  int   exp_load_q[$];
  int   exp_shift_q[$];
  int   exp_win_q[$];
  int   exp_score_q[$];
  int   exp_lose_q[$];
  off_t exp_off_q[$];

  stop_it_ctrl #(
    .SHIFT_PERIOD(SP),
    .BLINK_PERIOD(BP),
    .BLINK_COUNT (BC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .target_i (target_i),
    .leds_i   (leds),
    .shift_o  (shift_o),
    .load_o   (load_o),
    .off_o    (off_o),
    .running_o(running_o),
    .win_o    (win_o),
    .lose_o   (lose_o),
    .score_o  (score_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shifter model: load clears (switch pattern 0), shift fills a lit LED from the bottom.
  always @(posedge clk) begin
    if (load_o)       leds <= 16'h0000;
    else if (shift_o) leds <= {leds[14:0], 1'b1};
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    int exp_off;
    if (load_o) begin
      if (exp_load_q.size() == 0) chk("load_unexp", cyc, -1);
      else chk("load_cyc", cyc, exp_load_q.pop_front());
    end
    if (shift_o) begin
      if (exp_shift_q.size() == 0) chk("shift_unexp", cyc, -1);
      else chk("shift_cyc", cyc, exp_shift_q.pop_front());
    end
    if (win_o) begin
      if (exp_win_q.size() == 0) chk("win_unexp", cyc, -1);
      else begin
        chk("win_cyc", cyc, exp_win_q.pop_front());
        chk("win_score", score_o, exp_score_q.pop_front());
      end
    end
    if (lose_o) begin
      if (exp_lose_q.size() == 0) chk("lose_unexp", cyc, -1);
      else begin
        chk("lose_cyc", cyc, exp_lose_q.pop_front());
        chk("lose_score", score_o, score_m);
      end
    end
    if (shift_o || load_o) chk("shift_load_excl", shift_o & load_o, 0);
    if (win_o || lose_o)   chk("win_lose_excl", win_o & lose_o, 0);
    exp_off = 0;
    if (exp_off_q.size() != 0 && exp_off_q[0].cyc == cyc) exp_off = exp_off_q.pop_front().v;
    chk("off", off_o, exp_off);
  end

  // One game: start, ns shifts, stop 'extra' cycles after the ns-th shift; rst_at>0 resets mid-WIN.
  task automatic play(input int tgt, input int ns, input int extra, input int rst_at);
    int   n, m, r;
    bit   hit;
    off_t e;
    n = cyc + 1;
    goto(n);
    target_i = 4'(tgt);
    start_i  = 1'b1;
    exp_load_q.push_back(n + 1);
    for (int k = 1; k <= ns; k++) exp_shift_q.push_back(n + 1 + SP * k);
    m = n + 1 + SP * ns + extra;
    goto(n + 1);
    start_i = 1'b0;
    chk("running_load", running_o, 0);
    goto(n + 2);
    chk("running_on", running_o, 1);
    goto(n + 3);
    start_i = 1'b1;
    goto(n + 4);
    start_i = 1'b0;
    goto(m);
    stop_i = 1'b1;
    hit = (ns == tgt + 1);
    if (hit) begin
      score_m = (score_m < 15) ? score_m + 1 : 15;
      exp_win_q.push_back(m + 2);
      exp_score_q.push_back(score_m);
      for (int i = 0; i < 2 * BC * BP; i++) begin
        e.cyc = m + 2 + i;
        e.v   = ((i / BP) % 2 == 0) ? 1 : 0;
        exp_off_q.push_back(e);
      end
    end else begin
      exp_lose_q.push_back(m + 2);
    end
    goto(m + 1);
    stop_i = 1'b0;
    chk("running_judge", running_o, 0);
    goto(m + 4);
    stop_i = 1'b1;
    goto(m + 5);
    stop_i = 1'b0;
    if (hit && rst_at == 0) begin
      goto(m + 6);
      start_i = 1'b1;
      goto(m + 7);
      start_i = 1'b0;
    end
    if (rst_at > 0) begin
      r = m + 2 + rst_at;
      goto(r);
      rst_i = 1'b1;
      goto(r + 1);
      rst_i = 1'b0;
      exp_off_q.delete();
      score_m = 0;
      chk("rst_off", off_o, 0);
      chk("rst_score", score_o, 0);
      chk("rst_running", running_o, 0);
    end
    goto(m + 16);
    chk("idle_running", running_o, 0);
    chk("end_score", score_o, score_m);
  endtask

  task automatic play_full();
    int n;
    n = cyc + 1;
    goto(n);
    target_i = 4'd7;
    start_i  = 1'b1;
    exp_load_q.push_back(n + 1);
    for (int k = 1; k <= 16; k++) exp_shift_q.push_back(n + 1 + SP * k);
    exp_lose_q.push_back(n + 3 + SP * 16);
    goto(n + 1);
    start_i = 1'b0;
    goto(n + 2 + SP * 16);
    chk("full_running", running_o, 1);
    goto(n + 3 + SP * 16);
    chk("full_lose_state", running_o, 0);
    goto(n + 6 + SP * 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i    = 1'b1;
    start_i  = 1'b1;
    stop_i   = 1'b0;
    target_i = 4'd0;
    goto(3);
    rst_i = 1'b0;
    goto(4);
    chk("rst_score0", score_o, 0);
    chk("rst_running0", running_o, 0);
    chk("rst_off0", off_o, 0);
    chk("rst_win0", win_o, 0);
    chk("rst_lose0", lose_o, 0);
    chk("rst_load0", load_o, 0);
    goto(8);
    start_i = 1'b0;
    goto(10);

    play(2, 3, 1, 0);      // win at 16'h0007
    play(2, 4, 2, 0);      // lose at 16'h000F
    play(2, 3, 4, 0);      // stop coincides with tick==3
    play(0, 1, 3, 0);      // win on LED 0
    play_full();           // never stopped
    play(5, 2, 1, 0);      // early miss
    for (int g = 0; g < 16; g++) play(2, 3, 1 + (g % 4), 0);
    chk("score_sat", score_o, 15);
    play(2, 3, 1, 6);      // reset in the middle of WIN
    play(2, 3, 2, 0);

    chk("pend_load", exp_load_q.size(), 0);
    chk("pend_shift", exp_shift_q.size(), 0);
    chk("pend_win", exp_win_q.size(), 0);
    chk("pend_lose", exp_lose_q.size(), 0);
    chk("pend_off", exp_off_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stop_it_ctrl.md
# stop_it_ctrl

Game sequencer for the 16-LED shifter datapath: decides when the shifter loads the switch pattern, when it shifts in a lit LED, and when the display is blanked. It edge-detects start/stop buttons, paces shifts with a cycle-count timer, judges a stop against a target LED position, keeps a saturating score, and plays a blink animation on a win. It sits between the debounced button inputs and the shifter's `shift_i`/`load_i`/`off_i`, with the shifter's `leds_o` fed back as `leds_i`.

## Interface
- `SHIFT_PERIOD`, default 1000000: clock cycles between shift pulses; ≥2.
- `BLINK_PERIOD`, default 4000000: cycles per blink half-period; ≥1.
- `BLINK_COUNT`, default 4: off/on blink pairs in the win animation; ≥1.
- `clk_i  in  1`: single clock; all state on rising edge.
- `rst_i  in  1`: synchronous, active-high reset.
- `start_i  in  1`: start button level; debounced and synchronized upstream.
- `stop_i  in  1`: stop button level; debounced and synchronized upstream.
- `target_i  in  4`: LED index the player aims to stop on.
- `leds_i  in  16`: shifter `leds_o`, unblanked whenever judging.
- `shift_o  out  1`: to shifter `shift_i`.
- `load_o  out  1`: to shifter `load_i`.
- `off_o  out  1`: to shifter `off_i`.
- `running_o  out  1`: high in RUN.
- `win_o  out  1`: one-cycle pulse on a win.
- `lose_o  out  1`: one-cycle pulse on a loss.
- `score_o  out  4`: win count, saturates at 15.

## Operation
- Edge detect: `start_e = start_i & ~start_q`, `stop_e = stop_i & ~stop_q`. `start_q` and `stop_q` reset to 1, so a button held through reset produces no edge.
- States: IDLE, LOAD, RUN, JUDGE, WIN, LOSE.
- IDLE / LOSE: all strobes low, `off_o=0`. On `start_e`, go to LOAD.
- LOAD: `load_o=1` for exactly one cycle. Clear the tick counter. Go to RUN.
- RUN: the tick counter counts 0..SHIFT_PERIOD-1 and wraps.
  - `shift_o=1` when tick == SHIFT_PERIOD-1 and `stop_e` is low.
  - `stop_e` has priority: go to JUDGE with no shift that cycle.
  - Otherwise, if `leds_i == 16'hFFFF`, go to LOSE. `lose_o` pulses on the transition.
  - `start_e` is ignored.
- JUDGE: one cycle. `hit = leds_i[target_i] & (target_i==15 | ~leds_i[target_i+1])`, i.e. the fill front sits exactly at the target.
  - hit: go to WIN, assert `win_o`, increment `score_o` (saturating).
  - miss: go to LOSE, assert `lose_o`.
- WIN: blink counter plus half-period timer.
  - `off_o=1` for the first BLINK_PERIOD cycles, then 0 for BLINK_PERIOD cycles; repeat BLINK_COUNT times.
  - Then go to IDLE with `off_o=0`.
  - `start_e` and `stop_e` are ignored during WIN.
- `shift_o` and `load_o` are never high together. No strobe is high outside RUN/LOAD.
- Reset (any state, any cycle): state IDLE, all counters 0, `score_o=0`, all outputs 0, edge registers 1.

## Timing
- `start_e` sampled in cycle N: LOAD with `load_o=1` in N+1; RUN from N+2 with tick=0; first `shift_o` in cycle N+1+SHIFT_PERIOD; then every SHIFT_PERIOD cycles.
- `stop_e` in cycle M (RUN): JUDGE in M+1; `win_o`/`lose_o` high in M+2 (first cycle of WIN/LOSE); `score_o` updated from M+2.
- The full-lose check uses `leds_i` of the current cycle. `lose_o` is high in the first LOSE cycle.
- WIN lasts exactly 2·BLINK_COUNT·BLINK_PERIOD cycles; IDLE follows.
- `win_o` and `lose_o` are mutually exclusive, one cycle each.
- `shift_o` and `load_o` are combinational from state/counters (`shift_o` also gated by `stop_e`). All other outputs come from registers.

## Test plan
- Use SHIFT_PERIOD=4, BLINK_PERIOD=3, BLINK_COUNT=2 for all scenarios.
- Reset with `start_i` held high: no LOAD after release; all outputs 0, `score_o=0`.
- Start (shifter loaded 16'h0000): `load_o` one cycle at N+1; `shift_o` at N+5, N+9, N+13; `running_o` high from N+2.
- `target_i=2`, stop when `leds_i=16'h0007`: `win_o` pulse, `score_o=1`; `off_o` sequence 1,1,1,0,0,0,1,1,1,0,0,0, then IDLE.
- `target_i=2`, stop at `16'h000F`: `lose_o` pulse, score unchanged, `off_o=0`; a new `start_e` gives `load_o`.
- `stop_e` on the same cycle as tick==3: no `shift_o`, JUDGE next.
- Never stop: after 16 shifts `leds_i=FFFF` gives a `lose_o` pulse; 16 consecutive wins hold `score_o=15`; `rst_i` mid-WIN gives IDLE and `off_o=0` the next cycle.
